// File: rtl/serial_c2_negator.sv
// serial_c2_negator: two's complement negation of a WIDTH-bit operand,
// computed two bits per cycle through a single 2-bit slice.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Input side: x is taken when in_valid & in_ready (in_ready is 1
// exactly in IDLE). Output side: z/ow are taken when out_valid & out_ready
// (out_valid is 1 exactly in DONE). Valid may rise without waiting for ready,
// and the result holds unchanged while out_valid=1 and out_ready=0.
module serial_c2_negator #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ow,
  output logic [1:0]       state_dbg
);

  localparam int SLICES = WIDTH / 2;
  localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] z_q;
  logic             ow_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;

  logic       accept;
  logic       last_slice;
  logic [1:0] x_pair;
  logic [2:0] sum;

  // Slice datapath: {carry_out, s1_s0} = ~x1_x0 + carry_in for the current index.
  always_comb begin
    x_pair     = x_q[{idx_q, 1'b0} +: 2];
    sum        = {1'b0, ~x_pair} + {2'b00, carry_q};
    last_slice = (idx_q == LAST_IDX);
  end

  // Next-state and handshake outputs; accept and result transfer live in
  // different states, so they can never happen on the same edge.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand capture, per-slice result write-back and carry/index ripple.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= '0;
      z_q     <= '0;
      ow_q    <= 1'b0;
      carry_q <= 1'b1;
      idx_q   <= '0;
    end else if (accept) begin
      x_q     <= x;
      carry_q <= 1'b1;
      idx_q   <= '0;
    end else if (state_q == BUSY) begin
      z_q[{idx_q, 1'b0} +: 2] <= sum[1:0];
      carry_q                 <= sum[2];
      if (last_slice) begin
        // Overflow only when both operand and result are negative (x = 100..0).
        ow_q  <= x_q[WIDTH-1] & sum[1];
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + IDXW'(1);
      end
    end
  end

  assign z         = z_q;
  assign ow        = ow_q;
  assign state_dbg = state_q;

endmodule

// File: doc/serial_c2_negator.md
SERIAL_C2_NEGATOR -- requirements
Module: serial_c2_negator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; it SHALL be even and at least 2.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operand on x is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts an operand this cycle.
REQ-006 The block SHALL have port x, input, WIDTH, the two's complement operand.
REQ-007 The block SHALL have port out_valid, output, 1, meaning z and ow hold a completed result.
REQ-008 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-009 The block SHALL have port z, output, WIDTH, the two's complement negation of the accepted x.
REQ-010 The block SHALL have port ow, output, 1, the overflow flag.

Function
REQ-011 The block SHALL compute z = -x modulo 2^WIDTH, two bits per cycle, through a single 2-bit slice.
REQ-012 Each slice SHALL compute {carry_out, s1_s0} = ~x1_x0 + carry_in; carry_in for slice 0 SHALL be 1; carry SHALL ripple in a register between cycles.
REQ-013 The FSM SHALL have three states, IDLE, BUSY and DONE, and SHALL reset to IDLE.
REQ-014 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-015 IDLE with in_valid=1 at an edge: capture x; set slice index=0 and carry=1; go to BUSY.
REQ-016 BUSY: each edge processes slice index i (bits 2i+1:2i), writes the result bits into the z register, and increments i.
REQ-017 The edge processing slice WIDTH/2-1 SHALL move the FSM to DONE; latency from the accepting edge to out_valid=1 SHALL be WIDTH/2 edges (4 for WIDTH=8).
REQ-018 ow SHALL equal x[WIDTH-1] & z[WIDTH-1] of the accepted operand; it SHALL be 1 only for x = 100..0.
REQ-019 DONE: z and ow SHALL hold stable while out_ready=0; out_ready=1 at an edge SHALL return the FSM to IDLE.
REQ-020 in_valid SHALL be ignored in BUSY and DONE; x changes outside the accepting edge SHALL NOT affect the result.
REQ-021 An accept and a result transfer SHALL never occur on the same edge; the minimum spacing between accepts is WIDTH/2+2 cycles.
REQ-022 z and ow SHALL be registered; their values outside DONE are don't-care, except after reset.
REQ-023 The slice index SHALL be ceil(log2(WIDTH/2)) bits wide, minimum 1, and SHALL never wrap while in BUSY.

Reset
REQ-024 reset=1 at an edge SHALL force state=IDLE, in_ready=1, out_valid=0, z=0, ow=0, carry=1 and index=0, overriding all other inputs.
REQ-025 A reset during BUSY or DONE SHALL discard the operation in progress; no result SHALL be presented for it.
REQ-026 With reset=1 and in_valid=1 on the same edge, the operand SHALL NOT be accepted.

Verification
REQ-027 WIDTH=8: x=0x01 accepted -> out_valid after 4 edges; z=0xFF, ow=0.
REQ-028 x=0x00 -> z=0x00, ow=0; x=0x7F -> z=0x81, ow=0; x=0xFE -> z=0x02, ow=0.
REQ-029 x=0x80 -> z=0x80, ow=1.
REQ-030 Back-pressure: x=0x05 with out_ready held 0 for 6 cycles -> z=0xFB stable, out_valid=1, in_ready=0 throughout; a new in_valid with x=0x11 is ignored; out_ready=1 -> IDLE next edge.
REQ-031 Reset mid-BUSY after 2 slices of x=0x33 -> next cycle IDLE, z=0, ow=0, out_valid=0; a following x=0x02 yields z=0xFE.
REQ-032 Random back-to-back operands with random out_ready -> every z matches the -x mod 256 reference model, with no lost or duplicated results.
